gpu_stencil_mask_ctrl: RTL and testbench

//  Upstream sequencer for gpu_stencil_cache: turns 16-pixel span write requests into stencil read/eval/write.

---
 rtl/gpu_stencil_mask_ctrl_if.sv | 29 ++
 rtl/gpu_stencil_mask_ctrl.sv | 116 +++++++++++
 tb/tb_gpu_stencil_mask_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_stencil_mask_ctrl_if.sv
// rtl/gpu_stencil_mask_ctrl_if.sv - span request and pixel-writer output streams of the stencil mask sequencer
interface gpu_stencil_mask_ctrl_if;
  logic         span_valid_i;
  logic         span_ready_o;
  logic [14:0]  span_addr_i;
  logic [15:0]  span_sel_i;
  logic [255:0] span_color_i;
  logic         check_mask_i;
  logic         set_mask_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [14:0]  out_addr_o;
  logic [15:0]  out_en_o;
  logic [255:0] out_color_o;

  modport slave (
    input  span_valid_i, span_addr_i, span_sel_i, span_color_i, check_mask_i, set_mask_i,
    output span_ready_o,
    output out_valid_o, out_addr_o, out_en_o, out_color_o,
    input  out_ready_i
  );

  modport master (
    output span_valid_i, span_addr_i, span_sel_i, span_color_i, check_mask_i, set_mask_i,
    input  span_ready_o,
    input  out_valid_o, out_addr_o, out_en_o, out_color_o,
    output out_ready_i
  );
endinterface

// File: rtl/gpu_stencil_mask_ctrl.sv
// rtl/gpu_stencil_mask_ctrl.sv - stencil read/eval/write sequencer in front of gpu_stencil_cache
module gpu_stencil_mask_ctrl #(
  parameter int STAT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  gpu_stencil_mask_ctrl_if.slave span_if,
  output logic                  stencil_rd_req_o,
  output logic [14:0]           stencil_rd_addr_o,
  input  logic [15:0]           stencil_rd_value_i,
  output logic                  stencil_wr_req_o,
  output logic [14:0]           stencil_wr_addr_o,
  output logic [15:0]           stencil_wr_mask_o,
  output logic [15:0]           stencil_wr_value_o,
  input  logic                  stencil_error_i,
  output logic                  sticky_error_o,
  output logic [STAT_W-1:0]     masked_cnt_o
);

  typedef enum logic [1:0] {IDLE, CAP, OUT} state_e;

  state_e       state_q, state_d;
  logic [14:0]  addr_q;
  logic [15:0]  sel_q, en_q, en_d;
  logic [255:0] color_q;
  logic         check_q, set_q;
  logic         accept, cnt_inc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Read value from the cache is only valid in CAP, so the enable mask is captured there.
  always_comb begin
    state_d                = state_q;
    accept                 = 1'b0;
    cnt_inc                = 1'b0;
    span_if.span_ready_o   = 1'b0;
    span_if.out_valid_o    = 1'b0;
    stencil_rd_req_o       = 1'b0;
    stencil_rd_addr_o      = 15'h0;
    stencil_wr_req_o       = 1'b0;
    stencil_wr_addr_o      = 15'h0;
    stencil_wr_mask_o      = 16'h0;
    stencil_wr_value_o     = 16'h0;
    en_d = sel_q & ~(check_q ? stencil_rd_value_i : 16'h0);
    case (state_q)
      IDLE: begin
        span_if.span_ready_o = 1'b1;
        if (span_if.span_valid_i) begin
          accept = 1'b1;
          if (|span_if.span_sel_i) begin
            stencil_rd_req_o  = 1'b1;
            stencil_rd_addr_o = span_if.span_addr_i;
            state_d           = CAP;
          end
        end
      end
      CAP: begin
        if (en_d == 16'h0) begin
          cnt_inc = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        span_if.out_valid_o = 1'b1;
        if (span_if.out_ready_i) begin
          stencil_wr_req_o   = 1'b1;
          stencil_wr_addr_o  = addr_q;
          stencil_wr_mask_o  = en_q;
          stencil_wr_value_o = {16{set_q}};
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= 15'h0;
      sel_q   <= 16'h0;
      color_q <= 256'h0;
      check_q <= 1'b0;
      set_q   <= 1'b0;
      en_q    <= 16'h0;
    end else begin
      if (accept) begin
        addr_q  <= span_if.span_addr_i;
        sel_q   <= span_if.span_sel_i;
        color_q <= span_if.span_color_i;
        check_q <= span_if.check_mask_i;
        set_q   <= span_if.set_mask_i;
      end
      if (state_q == CAP) en_q <= en_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_error_o <= 1'b0;
      masked_cnt_o   <= '0;
    end else begin
      if (stencil_error_i) sticky_error_o <= 1'b1;
      if (cnt_inc && (masked_cnt_o != {STAT_W{1'b1}})) masked_cnt_o <= masked_cnt_o + 1'b1;
    end
  end

  assign span_if.out_addr_o  = addr_q;
  assign span_if.out_en_o    = en_q;
  assign span_if.out_color_o = color_q;

endmodule

// File: tb/tb_gpu_stencil_mask_ctrl.sv
// tb/tb_gpu_stencil_mask_ctrl.sv - randomized bench with stencil cache model and span-level reference
module tb_gpu_stencil_mask_ctrl;
  localparam int STAT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpu_stencil_mask_ctrl_if sif();
  logic              rd_req, wr_req, err_in, sticky;
  logic [14:0]       rd_addr, wr_addr;
  logic [15:0]       rd_value, wr_mask, wr_value;
  logic [STAT_W-1:0] mcnt;

  gpu_stencil_mask_ctrl #(.STAT_W(STAT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .span_if(sif),
    .stencil_rd_req_o(rd_req), .stencil_rd_addr_o(rd_addr), .stencil_rd_value_i(rd_value),
    .stencil_wr_req_o(wr_req), .stencil_wr_addr_o(wr_addr), .stencil_wr_mask_o(wr_mask),
    .stencil_wr_value_o(wr_value), .stencil_error_i(err_in), .sticky_error_o(sticky),
    .masked_cnt_o(mcnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [14:0]  addr;
    logic [15:0]  en;
    logic [255:0] color;
    logic         set;
  } exp_t;

  logic [15:0]       mem [int];
  exp_t              exp_q [$];
  logic [STAT_W-1:0] mcnt_m;
  logic              sticky_m, rd_pend, hold, prev_valid;
  logic [15:0]       rd_data, hold_en, last_en, last_wmask, last_wval;
  logic [14:0]       hold_addr;
  logic [255:0]      hold_color;
  int                cyc = 0, acc_cyc = 0, first_out_cyc = 0, last_wr = -10, wr_cnt = 0;
  logic              poke_en;
  logic [14:0]       poke_addr;
  logic [15:0]       poke_val;

  function automatic logic [15:0] mem_rd(input logic [14:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 16'h0;
  endfunction

  // Cache read port: data valid only in the cycle after the request, garbage otherwise.
  always @(posedge clk) begin
    #1;
    rd_value = rd_pend ? rd_data : 16'($urandom);
  end

  always @(negedge clk) begin
    logic [15:0] en;
    exp_t e;
    cyc++;
    rd_pend = 1'b0;
    if (poke_en) mem[int'(poke_addr)] = poke_val;
    if (!rst_n) begin
      exp_q.delete();
      mcnt_m = '0; sticky_m = 1'b0; hold = 1'b0; last_wr = -10;
    end else begin
      check_eq("sticky_error", 256'(sticky), 256'(sticky_m));
      if (sif.span_ready_o) check_eq("masked_cnt", 256'(mcnt), 256'(mcnt_m));
      check_eq("rd_wr_exclusive", 256'(rd_req & wr_req), 256'(0));
      check_eq("wr_req_only_on_handshake", 256'(wr_req), 256'(sif.out_valid_o & sif.out_ready_i));
      if (hold && sif.out_valid_o) begin
        check_eq("hold_addr", 256'(sif.out_addr_o), 256'(hold_addr));
        check_eq("hold_en", 256'(sif.out_en_o), 256'(hold_en));
        check_eq("hold_color", sif.out_color_o, hold_color);
      end
      if (sif.span_valid_i && sif.span_ready_o) begin
        acc_cyc = cyc;
        if (sif.span_sel_i != 16'h0) begin
          check_eq("rd_req", 256'(rd_req), 256'(1));
          check_eq("rd_addr", 256'(rd_addr), 256'(sif.span_addr_i));
          rd_pend = 1'b1;
          rd_data = mem_rd(sif.span_addr_i);
          en = sif.span_sel_i & ~(sif.check_mask_i ? rd_data : 16'h0);
          if (en == 16'h0) begin
            if (mcnt_m != {STAT_W{1'b1}}) mcnt_m = mcnt_m + 1'b1;
          end else begin
            e.addr = sif.span_addr_i; e.en = en; e.color = sif.span_color_i; e.set = sif.set_mask_i;
            exp_q.push_back(e);
          end
        end else begin
          check_eq("rd_req_empty_sel", 256'(rd_req), 256'(0));
        end
      end
      if (sif.out_valid_o && !prev_valid) first_out_cyc = cyc;
      if (sif.out_valid_o && sif.out_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_output", 256'(1), 256'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("out_addr", 256'(sif.out_addr_o), 256'(e.addr));
          check_eq("out_en", 256'(sif.out_en_o), 256'(e.en));
          check_eq("out_color", sif.out_color_o, e.color);
          check_eq("wr_addr", 256'(wr_addr), 256'(e.addr));
          check_eq("wr_mask", 256'(wr_mask), 256'(e.en));
          check_eq("wr_value", 256'(wr_value), 256'(e.set ? 16'hFFFF : 16'h0000));
        end
        check_eq("wr_spacing_ok", 256'(cyc - last_wr >= 3), 256'(1));
        last_wr = cyc; wr_cnt++;
        last_en = sif.out_en_o; last_wmask = wr_mask; last_wval = wr_value;
        if (wr_req) mem[int'(wr_addr)] = (mem_rd(wr_addr) & ~wr_mask) | (wr_value & wr_mask);
      end
      hold = sif.out_valid_o & ~sif.out_ready_i;
      hold_addr = sif.out_addr_o; hold_en = sif.out_en_o; hold_color = sif.out_color_o;
      if (err_in) sticky_m = 1'b1;
    end
    prev_valid = sif.out_valid_o;
  end

  task automatic poke(input logic [14:0] a, input logic [15:0] v);
    @(posedge clk); #1;
    poke_addr = a; poke_val = v; poke_en = 1'b1;
    @(negedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic send_span(input logic [14:0] a, input logic [15:0] s, input logic chk, input logic st);
    bit ok;
    @(posedge clk); #1;
    sif.span_valid_i = 1'b1; sif.span_addr_i = a; sif.span_sel_i = s;
    sif.check_mask_i = chk; sif.set_mask_i = st;
    sif.span_color_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sif.span_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("accept_timeout", 256'(0), 256'(1));
    @(posedge clk); #1;
    sif.span_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sif.span_ready_o && !sif.out_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("idle_timeout", 256'(0), 256'(1));
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sif.out_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("out_valid_timeout", 256'(0), 256'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_out_valid"}, 256'(sif.out_valid_o), 256'(0));
    check_eq({tag, "_out_en"}, 256'(sif.out_en_o), 256'(0));
    check_eq({tag, "_out_addr"}, 256'(sif.out_addr_o), 256'(0));
    check_eq({tag, "_out_color"}, sif.out_color_o, 256'(0));
    check_eq({tag, "_rd_req"}, 256'(rd_req), 256'(0));
    check_eq({tag, "_wr_req"}, 256'(wr_req), 256'(0));
    check_eq({tag, "_wr_mask"}, 256'(wr_mask), 256'(0));
    check_eq({tag, "_sticky"}, 256'(sticky), 256'(0));
    check_eq({tag, "_masked_cnt"}, 256'(mcnt), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    sif.span_valid_i = 1'b0; sif.span_addr_i = '0; sif.span_sel_i = '0; sif.span_color_i = '0;
    sif.check_mask_i = 1'b0; sif.set_mask_i = 1'b0; sif.out_ready_i = 1'b1;
    err_in = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_val = '0;
    #1;
    check_reset_outputs("reset");
    check_eq("reset_span_ready", 256'(sif.span_ready_o), 256'(1));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send_span(15'h0010, 16'hFFFF, 1'b0, 1'b1);
    wait_idle();
    check_eq("t1_latency", 256'(first_out_cyc - acc_cyc), 256'(2));
    check_eq("t1_out_en", 256'(last_en), 256'(16'hFFFF));
    check_eq("t1_wr_mask", 256'(last_wmask), 256'(16'hFFFF));
    check_eq("t1_wr_value", 256'(last_wval), 256'(16'hFFFF));
    check_eq("t1_word", 256'(mem_rd(15'h0010)), 256'(16'hFFFF));
    send_span(15'h0010, 16'hFFFF, 1'b1, 1'b1);
    wait_idle();
    check_eq("t1_readback_masked", 256'(mcnt), 256'(1));

    poke(15'h0010, 16'h00FF);
    send_span(15'h0010, 16'h0FF0, 1'b1, 1'b0);
    wait_idle();
    check_eq("t2_out_en", 256'(last_en), 256'(16'h0F00));
    check_eq("t2_wr_mask", 256'(last_wmask), 256'(16'h0F00));
    check_eq("t2_wr_value", 256'(last_wval), 256'(16'h0000));
    check_eq("t2_word", 256'(mem_rd(15'h0010)), 256'(16'h00FF));

    poke(15'h0020, 16'hFFFF);
    w0 = wr_cnt;
    send_span(15'h0020, 16'h1234, 1'b1, 1'b1);
    wait_idle();
    check_eq("t3_masked_cnt", 256'(mcnt), 256'(2));
    check_eq("t3_no_write", 256'(wr_cnt), 256'(w0));
    for (int i = 0; i < 13; i++) begin
      send_span(15'h0020, 16'($urandom_range(1, 65535)), 1'b1, 1'b0);
      wait_idle();
    end
    check_eq("t3_cnt_at_max", 256'(mcnt), 256'(15));
    send_span(15'h0020, 16'h8001, 1'b1, 1'b0);
    wait_idle();
    check_eq("t3_cnt_saturated", 256'(mcnt), 256'(15));

    @(posedge clk); #1 sif.out_ready_i = 1'b0;
    w0 = wr_cnt;
    send_span(15'h0030, 16'hA5C3, 1'b0, 1'b1);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_span_ready_low", 256'(sif.span_ready_o), 256'(0));
      check_eq("t4_no_wr", 256'(wr_req), 256'(0));
    end
    @(posedge clk); #1 sif.out_ready_i = 1'b1;
    wait_idle();
    check_eq("t4_one_write", 256'(wr_cnt), 256'(w0 + 1));
    check_eq("t4_out_en", 256'(last_en), 256'(16'hA5C3));

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      sif.span_valid_i = 1'b1;
      sif.span_addr_i  = 15'h0040;
      sif.span_sel_i   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      sif.check_mask_i = 1'($urandom);
      sif.set_mask_i   = 1'($urandom);
      sif.span_color_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sif.out_ready_i  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    sif.span_valid_i = 1'b0; sif.out_ready_i = 1'b1;
    wait_idle();
    check_eq("t5_all_outputs_seen", 256'(exp_q.size()), 256'(0));
    check_eq("t5_no_error", 256'(sticky), 256'(0));

    @(posedge clk); #1 err_in = 1'b1;
    @(posedge clk); #1 err_in = 1'b0;
    @(negedge clk);
    check_eq("t6_sticky_set", 256'(sticky), 256'(1));

    w0 = wr_cnt;
    send_span(15'h0050, 16'hFFFF, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_cap");
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
    check_eq("t6_cap_no_write", 256'(wr_cnt), 256'(w0));

    sif.out_ready_i = 1'b0;
    send_span(15'h0050, 16'h0FF0, 1'b0, 1'b1);
    wait_out_valid();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_out");
    @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
    sif.out_ready_i = 1'b1;
    check_eq("t6_out_no_write", 256'(wr_cnt), 256'(w0));

    send_span(15'h0050, 16'h00F0, 1'b0, 1'b1);
    wait_idle();
    check_eq("t6_after_reset_en", 256'(last_en), 256'(16'h00F0));
    check_eq("t6_after_reset_write", 256'(wr_cnt), 256'(w0 + 1));
    check_eq("t6_after_reset_word", 256'(mem_rd(15'h0050) & 16'h00F0), 256'(16'h00F0));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
